// File: rtl/i2c_fanout_if.sv
// Signal bundle between the internal I2C master, the fanout block and the
// downstream open-drain bus pads. The fanout block uses the slave modport;
// whatever drives the master pins and pads uses the master modport.
interface i2c_fanout_if #(
    parameter int NBUS = 2
);
    logic [NBUS-1:0] bus_enable;
    logic            m_scl_i;
    logic            m_scl_o;
    logic            m_sda_t;
    logic            m_sda_o;
    logic [NBUS-1:0] s_scl_t;
    logic [NBUS-1:0] s_scl_i;
    logic [NBUS-1:0] s_sda_t;
    logic [NBUS-1:0] s_sda_i;
    logic [NBUS-1:0] active_mask;
    logic            busy;
    logic            stretch;

    modport master (
        output bus_enable, m_scl_i, m_sda_t, s_scl_i, s_sda_i,
        input  m_scl_o, m_sda_o, s_scl_t, s_sda_t, active_mask, busy, stretch
    );

    modport slave (
        input  bus_enable, m_scl_i, m_sda_t, s_scl_i, s_sda_i,
        output m_scl_o, m_sda_o, s_scl_t, s_sda_t, active_mask, busy, stretch
    );
endinterface

// File: rtl/i2c_fanout.sv
// I2C fanout: one internal master onto NBUS open-drain buses, with input
// synchronisation and glitch filtering, SDA ownership tracking, clock
// stretch passthrough and a bus mask that only changes between transactions.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | nobody drives SDA
// MDRIVE   | master holds SDA low, copied onto every active bus
// RELEASE  | master just let go; bus lows are its own echo and ignored
// SDRIVE   | a bus (owner) holds SDA low, reflected to the master only
module i2c_fanout #(
    parameter int  NBUS        = 2,
    parameter int  FILTER_LEN  = 4,
    parameter int  RELEASE_CYC = 64,
    localparam int OWNW        = (NBUS > 1) ? $clog2(NBUS) : 1
) (
    input  logic        clk,
    input  logic        rst,
    i2c_fanout_if.slave bus
);
    localparam int CNTW = $clog2(RELEASE_CYC) + 1;
    localparam int FCW  = $clog2(FILTER_LEN) + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MDRIVE  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_SDRIVE  = 2'd3;

    logic [NBUS-1:0] scl_s1, scl_s2, sda_s1, sda_s2;
    logic [NBUS-1:0] scl_filt, sda_filt;
    logic [FCW-1:0]  scl_cnt [NBUS];
    logic [FCW-1:0]  sda_cnt [NBUS];

    logic            m_sda_q, m_scl_q;
    logic            start, stop;
    logic            busy_q;
    logic [NBUS-1:0] mask_q;

    logic [1:0]      state, state_next;
    logic [OWNW-1:0] owner, owner_next, low_idx;
    logic [CNTW-1:0] rel_cnt;
    logic [NBUS-1:0] sda_high, sda_low;
    logic            any_low, owner_high, rel_timeout;

    logic [NBUS-1:0] s_scl_q, s_sda_q;
    logic            m_scl_o_q, m_sda_o_q, stretch_q, stretch_next;

    // Two-flop synchronisers on every pad input; idle bus level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1 <= '1;
            scl_s2 <= '1;
            sda_s1 <= '1;
            sda_s2 <= '1;
        end else begin
            scl_s1 <= bus.s_scl_i;
            scl_s2 <= scl_s1;
            sda_s1 <= bus.s_sda_i;
            sda_s2 <= sda_s1;
        end
    end

    // Glitch filter: output follows only after FILTER_LEN equal new samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NBUS; i++) begin
                scl_cnt[i] <= '0;
                sda_cnt[i] <= '0;
            end
            scl_filt <= '1;
            sda_filt <= '1;
        end else begin
            for (int i = 0; i < NBUS; i++) begin
                if (scl_s2[i] == scl_filt[i]) begin
                    scl_cnt[i] <= '0;
                end else if (scl_cnt[i] == FCW'(FILTER_LEN - 1)) begin
                    scl_filt[i] <= scl_s2[i];
                    scl_cnt[i]  <= '0;
                end else begin
                    scl_cnt[i] <= scl_cnt[i] + 1'b1;
                end

                if (sda_s2[i] == sda_filt[i]) begin
                    sda_cnt[i] <= '0;
                end else if (sda_cnt[i] == FCW'(FILTER_LEN - 1)) begin
                    sda_filt[i] <= sda_s2[i];
                    sda_cnt[i]  <= '0;
                end else begin
                    sda_cnt[i] <= sda_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Edges are taken between the registered and live master pins; SCL must
    // be high on both sides so an SCL fall with SDA cannot fake a START.
    assign start = m_scl_q & bus.m_scl_i & m_sda_q & ~bus.m_sda_t;
    assign stop  = m_scl_q & bus.m_scl_i & ~m_sda_q & bus.m_sda_t;

    // Transaction tracking and mask capture; the STOP cycle already loads the new mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_sda_q <= 1'b1;
            m_scl_q <= 1'b1;
            busy_q  <= 1'b0;
            mask_q  <= '0;
        end else begin
            m_sda_q <= bus.m_sda_t;
            m_scl_q <= bus.m_scl_i;
            if (start) begin
                busy_q <= 1'b1;
            end else if (stop) begin
                busy_q <= 1'b0;
            end
            if ((!busy_q || stop) && !start) begin
                mask_q <= bus.bus_enable;
            end
        end
    end

    // Inactive buses read as released.
    assign sda_high    = sda_filt | ~mask_q;
    assign sda_low     = ~sda_high;
    assign any_low     = |sda_low;
    assign owner_high  = sda_high[owner];
    assign rel_timeout = (rel_cnt == CNTW'(RELEASE_CYC - 1));

    // Lowest-numbered bus holding SDA low.
    always_comb begin
        low_idx = '0;
        for (int i = NBUS - 1; i >= 0; i--) begin
            if (sda_low[i]) begin
                low_idx = OWNW'(i);
            end
        end
    end

    // SDA ownership next-state; the master always wins over a bus low in IDLE.
    always_comb begin
        state_next = state;
        owner_next = owner;
        case (state)
            ST_IDLE: begin
                if (!bus.m_sda_t) begin
                    state_next = ST_MDRIVE;
                end else if (any_low) begin
                    state_next = ST_SDRIVE;
                    owner_next = low_idx;
                end
            end
            ST_MDRIVE: begin
                if (bus.m_sda_t) begin
                    state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!bus.m_sda_t) begin
                    state_next = ST_MDRIVE;
                end else if (!any_low) begin
                    state_next = ST_IDLE;
                end else if (rel_timeout) begin
                    state_next = ST_SDRIVE;
                    owner_next = low_idx;
                end
            end
            ST_SDRIVE: begin
                if (owner_high) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state, saturating release counter and registered SDA outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= '0;
            rel_cnt   <= '0;
            s_sda_q   <= '1;
            m_sda_o_q <= 1'b1;
        end else begin
            state <= state_next;
            owner <= owner_next;
            if (state == ST_RELEASE && state_next == ST_RELEASE) begin
                if (rel_cnt != '1) begin
                    rel_cnt <= rel_cnt + 1'b1;
                end
            end else begin
                rel_cnt <= '0;
            end
            s_sda_q   <= (state_next == ST_MDRIVE) ? ~mask_q : '1;
            m_sda_o_q <= !(state_next == ST_MDRIVE || state_next == ST_SDRIVE);
        end
    end

    assign stretch_next = bus.m_scl_i & (|(mask_q & ~scl_filt));

    // SCL fanout and stretch reflection back to the master.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_scl_q   <= '1;
            m_scl_o_q <= 1'b1;
            stretch_q <= 1'b0;
        end else begin
            s_scl_q   <= {NBUS{bus.m_scl_i}} | ~mask_q;
            m_scl_o_q <= bus.m_scl_i & ~stretch_next;
            stretch_q <= stretch_next;
        end
    end

    assign bus.s_scl_t     = s_scl_q;
    assign bus.s_sda_t     = s_sda_q;
    assign bus.m_scl_o     = m_scl_o_q;
    assign bus.m_sda_o     = m_sda_o_q;
    assign bus.active_mask = mask_q;
    assign bus.busy        = busy_q;
    assign bus.stretch     = stretch_q;
endmodule

// File: tb/tb_i2c_fanout.sv
// Bench for i2c_fanout (NBUS=2, defaults). Stimulus pushes expected values
// tagged with the cycle they are due; a negedge monitor pops and compares.
module tb_i2c_fanout;
    localparam int NB = 2;

    localparam int SIG_MSCLO   = 0;
    localparam int SIG_MSDAO   = 1;
    localparam int SIG_SSCLT   = 2;
    localparam int SIG_SSDAT   = 3;
    localparam int SIG_MASK    = 4;
    localparam int SIG_BUSY    = 5;
    localparam int SIG_STRETCH = 6;

    typedef struct {
        int unsigned cyc;
        int          sig;
        logic [7:0]  val;
        string       name;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] ext_scl = '1;
    logic [NB-1:0] ext_sda = '1;
    int unsigned   cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    bit            flush = 1'b0;
    exp_t          sb[$];
    logic [7:0]    mon_act;
    logic [7:0]    data;

    i2c_fanout_if #(.NBUS(NB)) bus_if ();

    // Open-drain pads: low if the fanout or the external device pulls low.
    assign bus_if.s_scl_i = bus_if.s_scl_t & ext_scl;
    assign bus_if.s_sda_i = bus_if.s_sda_t & ext_sda;

    i2c_fanout #(.NBUS(NB), .FILTER_LEN(4), .RELEASE_CYC(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(input int sig);
        case (sig)
            SIG_MSCLO:   return {7'b0, bus_if.m_scl_o};
            SIG_MSDAO:   return {7'b0, bus_if.m_sda_o};
            SIG_SSCLT:   return {6'b0, bus_if.s_scl_t};
            SIG_SSDAT:   return {6'b0, bus_if.s_sda_t};
            SIG_MASK:    return {6'b0, bus_if.active_mask};
            SIG_BUSY:    return {7'b0, bus_if.busy};
            SIG_STRETCH: return {7'b0, bus_if.stretch};
            default:     return 8'h00;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input int d, input int sig, input logic [7:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + d;
        e.sig  = sig;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: compare every entry that falls due this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc || flush) begin
                n_checks++;
                mon_act = actual(sb[i].sig);
                if (sb[i].cyc != cyc) begin
                    n_fail++;
                    $display("FAIL %s: not sampled (due cycle %0d, now %0d)", sb[i].name, sb[i].cyc, cyc);
                end else if (mon_act !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s: cycle %0d got %0h expected %0h", sb[i].name, cyc, mon_act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        bus_if.bus_enable = 2'b11;
        bus_if.m_scl_i    = 1'b1;
        bus_if.m_sda_t    = 1'b1;
        data              = 8'hA6;

        // Reset and first cycle after it
        tick(3);
        expect_at(0, SIG_MASK, 8'h0, "rst_mask");
        expect_at(0, SIG_SSDAT, 8'h3, "rst_sda_t");
        expect_at(0, SIG_BUSY, 8'h0, "rst_busy");
        rst = 1'b0;
        expect_at(1, SIG_MASK, 8'h3, "post_rst_mask");
        expect_at(1, SIG_SSCLT, 8'h3, "post_rst_scl_t");
        expect_at(1, SIG_SSDAT, 8'h3, "post_rst_sda_t");
        expect_at(1, SIG_MSCLO, 8'h1, "post_rst_m_scl_o");
        expect_at(1, SIG_MSDAO, 8'h1, "post_rst_m_sda_o");
        expect_at(1, SIG_BUSY, 8'h0, "post_rst_busy");
        expect_at(1, SIG_STRETCH, 8'h0, "post_rst_stretch");
        tick(1);
        bus_if.m_scl_i = 1'b0;
        expect_at(1, SIG_SSCLT, 8'h0, "scl_fanout_low");
        tick(1);
        bus_if.m_scl_i = 1'b1;
        expect_at(1, SIG_SSCLT, 8'h3, "scl_fanout_high");
        tick(20);

        // START, byte 0xA6, mask change mid-byte
        bus_if.m_sda_t = 1'b0;
        expect_at(1, SIG_BUSY, 8'h1, "start_busy");
        expect_at(1, SIG_SSDAT, 8'h0, "start_sda_t");
        tick(4);
        for (int i = 7; i >= 0; i--) begin
            bus_if.m_scl_i = 1'b0;
            tick(4);
            bus_if.m_sda_t = data[i];
            expect_at(1, SIG_SSDAT, data[i] ? 8'h3 : 8'h0, "bit_sda_t");
            if (i == 4) begin
                bus_if.bus_enable = 2'b01;
                expect_at(1, SIG_MASK, 8'h3, "freeze_mask");
                expect_at(1, SIG_BUSY, 8'h1, "mid_byte_busy");
            end
            tick(4);
            bus_if.m_scl_i = 1'b1;
            tick(8);
        end

        // ACK from bus 1
        bus_if.m_scl_i = 1'b0;
        tick(4);
        bus_if.m_sda_t = 1'b1;
        tick(20);
        ext_sda = 2'b01;
        expect_at(6, SIG_MSDAO, 8'h1, "ack_pre");
        expect_at(7, SIG_MSDAO, 8'h0, "ack_latency");
        expect_at(1, SIG_SSDAT, 8'h3, "ack_sda_t_a");
        expect_at(7, SIG_SSDAT, 8'h3, "ack_sda_t_b");
        expect_at(12, SIG_SSDAT, 8'h3, "ack_sda_t_c");
        tick(2);
        bus_if.m_scl_i = 1'b1;
        tick(8);
        bus_if.m_scl_i = 1'b0;
        tick(4);
        ext_sda = 2'b11;
        expect_at(6, SIG_MSDAO, 8'h0, "ack_hold");
        expect_at(7, SIG_MSDAO, 8'h1, "ack_release");
        tick(10);

        // STOP: busy falls and the pending mask loads together
        bus_if.m_sda_t = 1'b0;
        tick(4);
        bus_if.m_scl_i = 1'b1;
        tick(4);
        bus_if.m_sda_t = 1'b1;
        expect_at(0, SIG_BUSY, 8'h1, "pre_stop_busy");
        expect_at(0, SIG_MASK, 8'h3, "pre_stop_mask");
        expect_at(1, SIG_BUSY, 8'h0, "stop_busy");
        expect_at(1, SIG_MASK, 8'h1, "stop_mask");
        tick(10);
        bus_if.bus_enable = 2'b11;
        expect_at(1, SIG_MASK, 8'h3, "mask_reload");
        tick(10);

        // Loop-back lockout
        bus_if.m_scl_i = 1'b0;
        tick(3);
        bus_if.m_sda_t = 1'b0;
        ext_sda = 2'b10;
        tick(12);
        bus_if.m_sda_t = 1'b1;
        expect_at(1, SIG_MSDAO, 8'h1, "lock_m_sda_a");
        expect_at(5, SIG_MSDAO, 8'h1, "lock_m_sda_b");
        expect_at(9, SIG_MSDAO, 8'h1, "lock_m_sda_c");
        expect_at(5, SIG_SSDAT, 8'h3, "lock_sda_t_a");
        expect_at(10, SIG_SSDAT, 8'h3, "lock_sda_t_b");
        tick(10);
        ext_sda = 2'b11;
        expect_at(5, SIG_MSDAO, 8'h1, "lock_m_sda_d");
        expect_at(15, SIG_MSDAO, 8'h1, "lock_m_sda_e");
        tick(20);
        ext_sda = 2'b01;
        expect_at(6, SIG_MSDAO, 8'h1, "idle_after_lock_pre");
        expect_at(7, SIG_MSDAO, 8'h0, "idle_after_lock");
        tick(10);
        ext_sda = 2'b11;
        expect_at(7, SIG_MSDAO, 8'h1, "sdrive_exit");
        tick(15);

        // 3-cycle glitch is filtered out
        ext_sda = 2'b10;
        expect_at(5, SIG_MSDAO, 8'h1, "glitch_a");
        expect_at(7, SIG_MSDAO, 8'h1, "glitch_b");
        expect_at(8, SIG_MSDAO, 8'h1, "glitch_c");
        expect_at(10, SIG_MSDAO, 8'h1, "glitch_d");
        tick(3);
        ext_sda = 2'b11;
        tick(15);

        // Clock stretch from bus 0
        bus_if.m_scl_i = 1'b1;
        tick(20);
        ext_scl = 2'b10;
        expect_at(6, SIG_STRETCH, 8'h0, "stretch_pre");
        expect_at(7, SIG_STRETCH, 8'h1, "stretch_on");
        expect_at(7, SIG_MSCLO, 8'h0, "stretch_m_scl_on");
        expect_at(50, SIG_STRETCH, 8'h1, "stretch_mid");
        expect_at(50, SIG_MSCLO, 8'h0, "stretch_m_scl_mid");
        expect_at(50, SIG_SSCLT, 8'h3, "stretch_scl_t");
        expect_at(106, SIG_STRETCH, 8'h1, "stretch_last");
        expect_at(107, SIG_STRETCH, 8'h0, "stretch_off");
        expect_at(107, SIG_MSCLO, 8'h1, "stretch_m_scl_off");
        tick(100);
        ext_scl = 2'b11;
        tick(20);

        // RELEASE timeout into SDRIVE, owner 0
        bus_if.m_scl_i = 1'b0;
        tick(3);
        bus_if.m_sda_t = 1'b0;
        ext_sda = 2'b10;
        tick(10);
        bus_if.m_sda_t = 1'b1;
        expect_at(64, SIG_MSDAO, 8'h1, "timeout_pre");
        expect_at(65, SIG_MSDAO, 8'h0, "timeout_sdrive");
        expect_at(65, SIG_SSDAT, 8'h3, "timeout_sda_t");
        tick(70);
        bus_if.m_sda_t = 1'b0;
        expect_at(1, SIG_SSDAT, 8'h3, "sdrive_tolerate_sda_t");
        expect_at(1, SIG_MSDAO, 8'h0, "sdrive_tolerate_m_sda");
        tick(5);
        bus_if.m_sda_t = 1'b1;
        tick(5);
        ext_sda = 2'b11;
        expect_at(6, SIG_MSDAO, 8'h0, "owner_hold");
        expect_at(7, SIG_MSDAO, 8'h1, "owner0_release");
        tick(15);

        // Reset in the middle of a transaction
        bus_if.m_scl_i = 1'b1;
        tick(5);
        bus_if.m_sda_t = 1'b0;
        expect_at(1, SIG_BUSY, 8'h1, "rst_pre_busy");
        tick(3);
        rst = 1'b1;
        bus_if.m_sda_t = 1'b1;
        expect_at(1, SIG_SSDAT, 8'h3, "rst_sda_release");
        expect_at(1, SIG_BUSY, 8'h0, "rst_busy_clear");
        expect_at(1, SIG_MASK, 8'h0, "rst_mask_clear");
        tick(2);
        rst = 1'b0;
        expect_at(1, SIG_MASK, 8'h3, "rst_mask_reload");
        expect_at(1, SIG_MSDAO, 8'h1, "rst_m_sda_o");
        tick(10);

        for (int k = 0; k < 20 && sb.size() != 0; k++) tick(1);
        if (sb.size() != 0) begin
            flush = 1'b1;
            tick(1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_fanout.md
# i2c_fanout

Parametrised I2C bus fanout. It connects one internal I2C master (tri-state signal pair) to NBUS downstream open-drain buses. Unlike a plain combinational merge, it filters the bus inputs, tracks which side owns SDA so a released low cannot latch back through the loop, supports clock stretching from any active bus, and changes the per-bus enable mask only between transactions. It sits between the TURF I2C master core and the IOBUF pads of the board I2C segments; the pad buffers stay outside this block.

## Interface
- NBUS, 2: number of downstream buses, ≥1.
- FILTER_LEN, 4: consecutive equal samples required before a filtered bus input changes, ≥1.
- RELEASE_CYC, 64: maximum cycles in RELEASE before a still-low bus is treated as the SDA owner.
- OWNW, $clog2(NBUS) (min 1): owner-index width, derived, not overridable.

Ports (clock and reset first):
- clk  in  1  system clock; all logic in this one domain.
- rst  in  1  synchronous, active-high reset.
- bus_enable  in  NBUS  requested bus mask; sampled only while not busy.
- m_scl_i  in  1  master SCL (0 = drive low).
- m_scl_o  out  1  SCL seen by the master; low during stretching.
- m_sda_t  in  1  master SDA tristate (0 = drive low, 1 = release).
- m_sda_o  out  1  SDA seen by the master.
- s_scl_t  out  NBUS  bus SCL tristate (0 = drive low).
- s_scl_i  in  NBUS  bus SCL pad input.
- s_sda_t  out  NBUS  bus SDA tristate (0 = drive low).
- s_sda_i  in  NBUS  bus SDA pad input.
- active_mask  out  NBUS  mask in force for the current transaction.
- busy  out  1  high from master START to master STOP.
- stretch  out  1  high while a bus holds SCL low after the master has released it.

## Operation
- Input conditioning: each bit of s_scl_i and s_sda_i passes through a 2-FF synchronizer, then a glitch filter. The filter output changes only after FILTER_LEN consecutive samples of the new value. Master inputs are internal and are used unfiltered.
- Inactive buses (active_mask[i]=0): s_scl_t[i]=s_sda_t[i]=1. Their inputs are treated as high.
- SCL fanout: s_scl_t[i] <= m_scl_i | ~active_mask[i].
- Stretch: stretch <= m_scl_i & (any active bus with filtered SCL = 0). m_scl_o <= m_scl_i & ~stretch_next.
- START/STOP detection uses registered m_sda_t and m_scl_i. START is a falling edge on m_sda_t while m_scl_i=1; it sets busy. STOP is a rising edge on m_sda_t while m_scl_i=1; it clears busy. Repeated START leaves busy=1.
- active_mask <= bus_enable on every cycle where busy=0 and no START is detected that cycle. While busy, the mask is frozen.
- SDA ownership FSM. Each entry gives the outputs, then the exits.
  - IDLE: s_sda_t=all 1, m_sda_o=1.
    - m_sda_t=0 → MDRIVE. This takes priority over bus lows.
    - Otherwise, any active bus with filtered SDA low → SDRIVE. owner = lowest such index.
  - MDRIVE: s_sda_t[i]=~active_mask[i], m_sda_o=0.
    - m_sda_t=1 → RELEASE, and the release counter clears.
  - RELEASE: s_sda_t=all 1, m_sda_o=1. Bus SDA lows are ignored; this is the loop-back lockout.
    - m_sda_t=0 → MDRIVE.
    - All active filtered SDA high → IDLE.
    - Counter reaches RELEASE_CYC-1 with some active bus still low → SDRIVE, owner = lowest low index.
  - SDRIVE: s_sda_t=all 1 (no bus-to-bus propagation), m_sda_o=0.
    - Filtered SDA of owner high → IDLE.
    - m_sda_t=0 is tolerated and does not change state.
- rst mid-transaction: all bus drives are released within one cycle, busy clears, and the FSM returns to IDLE. The first cycle after reset loads active_mask from bus_enable.

## Timing
- Reset values:
  - s_scl_t, s_sda_t = all 1.
  - m_scl_o = 1, m_sda_o = 1.
  - busy = 0, stretch = 0.
  - active_mask = 0.
  - FSM = IDLE, owner = 0, filters and synchronizers = 1.
- Master → bus latency: 1 cycle, for both SCL and SDA (registered).
- Bus → master latency: 2 (sync) + FILTER_LEN (filter) + 1 (FSM/output register) cycles, from the s_sda_i/s_scl_i edge to the m_sda_o/m_scl_o change. This is 7 cycles with defaults.
- Release counter width is $clog2(RELEASE_CYC)+1. It saturates and does not wrap.
- Simultaneous master low and bus low in IDLE: the master wins (MDRIVE).
- Simultaneous STOP and bus_enable change: the new mask is loaded on the same cycle busy clears.

## Test plan
- Reset, bus_enable=2'b11: the cycle after rst deassert gives active_mask=2'b11 and all outputs at their reset values. m_scl_i=0 → s_scl_t=2'b00 one cycle later.
- Master write byte with ACK from bus 1 (NBUS=2, defaults):
  - Each master SDA low appears on s_sda_t[1:0] after 1 cycle.
  - The bus-1 ACK low reaches m_sda_o after 7 cycles.
  - s_sda_t[0] stays 1 throughout the ACK.
- Loop-back lockout: master releases SDA while the bus pad stays low for 10 cycles → FSM in RELEASE, m_sda_o=1, no return to MDRIVE/SDRIVE. The pad goes high → IDLE.
- Stretch: master releases SCL, bus 0 holds SCL low for 100 cycles → stretch=1 and m_scl_o=0 for that window (offset by 7 cycles). Both return to 1 after the pad releases.
- Mask freeze: START, change bus_enable 2'b11→2'b01 mid-byte → active_mask stays 2'b11 until STOP, then becomes 2'b01 on the same cycle busy falls.
- Glitch and timeout:
  - A 3-cycle low pulse on s_sda_i[0] in IDLE leaves m_sda_o=1.
  - A bus held low through RELEASE for 64 cycles → SDRIVE with owner=0 and m_sda_o=0.
